fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined processor, directly upstream of the decode stage and its main decoder. Owns the program counter and issues requests to instruction memory over a req/ack handshake with variable latency. Drives the IF/ID pipeline register (instruction, PC, valid) consumed by decode. Handles decode stalls with a one-entry hold buffer, and handles branch redirects from execute, including discarding a fetch already in flight.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/if_id_register.sv | 56 +++++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t     : fetch controller states
//   RESET_PC_DEFAULT  : default PC loaded on reset
//   PC_STEP_DEFAULT   : default PC increment per sequential fetch
//   BUBBLE_INSTR      : instruction word written into IF/ID on a flush
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HELD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  localparam int unsigned  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned  PC_STEP_DEFAULT  = 32'd4;
  // A zero word decodes as an R-type, so consumers must qualify on ValidD.
  localparam logic [31:0]  BUBBLE_INSTR     = 32'h0000_0000;

endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register feeding decode.
// Update priority: rst > flush > stall (hold) > load > bubble (valid drops).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_flush             : make IF/ID a bubble (valid=0, instr=BUBBLE_INSTR)
//   i_stall             : hold current contents
//   i_load              : a fetched instruction is available to load
//   i_instr, i_pc       : instruction and its PC to load
//   o_instr, o_pc       : registered instruction / PC
//   o_valid             : o_instr is real, not a bubble
module if_id_register
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_stall,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= INSTR_W'(BUBBLE_INSTR);
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= INSTR_W'(BUBBLE_INSTR);
      r_valid <= 1'b0;
    end else if (i_stall) begin
      // hold
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns PCF, talks to instruction memory
// over a req/ack handshake with variable latency, and drives IF/ID.
// Decode stalls are absorbed by a one-entry hold buffer; branch redirects
// from execute may discard a fetch already in flight.
// Optional feature macro: FETCH_PERF_EN adds FetchCount/StallCount/DiscardCount.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   StallD, FlushD                : decode stall / IF/ID flush
//   BranchTakenE, BranchTargetE   : redirect request and target
//   imem_req, imem_addr           : fetch request, stable until the ack cycle
//   imem_ack, imem_rdata          : one-cycle response strobe and data
//   InstrD, PCD, ValidD           : IF/ID outputs
//   FetchCount, StallCount,
//   DiscardCount                  : saturating perf counters (FETCH_PERF_EN)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEFAULT)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               BranchTakenE,
  input  logic [ADDR_W-1:0]  BranchTargetE,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [ADDR_W-1:0]  PCD,
  output logic               ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        FetchCount,
  output logic [31:0]        StallCount,
  output logic [15:0]        DiscardCount
`endif
);

  fetch_state_t       r_state, w_next;
  logic [ADDR_W-1:0]  r_pcf;
  logic [ADDR_W-1:0]  r_disc_addr;   // address of the request being drained in DISCARD
  logic [ADDR_W-1:0]  r_hold_pc;
  logic [INSTR_W-1:0] r_hold_instr;
  logic               w_load;
  logic [INSTR_W-1:0] w_load_instr;
  logic [ADDR_W-1:0]  w_load_pc;
  logic               w_req_ack;

  assign w_req_ack = (r_state == ST_REQ) && imem_ack;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next-state logic; redirect outranks stall handling
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = ST_REQ;
      ST_REQ: begin
        if (BranchTakenE)          w_next = imem_ack ? ST_REQ : ST_DISCARD;
        else if (imem_ack && StallD) w_next = ST_HELD;
      end
      ST_HELD: begin
        if (BranchTakenE || !StallD) w_next = ST_REQ;
      end
      // An ack here retires the doomed request; a redirect arriving in the
      // same cycle has no fetch left to kill, so go straight to REQ.
      ST_DISCARD: begin
        if (imem_ack) w_next = ST_REQ;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // outputs and IF/ID load source
  always_comb begin
    imem_req     = (r_state == ST_REQ) || (r_state == ST_DISCARD);
    imem_addr    = (r_state == ST_DISCARD) ? r_disc_addr : r_pcf;
    w_load       = 1'b0;
    w_load_instr = r_hold_instr;
    w_load_pc    = r_hold_pc;
    if (!BranchTakenE) begin
      if (w_req_ack) begin
        // With StallD high IF/ID ignores this; the word goes to the hold buffer.
        w_load       = 1'b1;
        w_load_instr = imem_rdata;
        w_load_pc    = r_pcf;
      end else if (r_state == ST_HELD) begin
        w_load = 1'b1;
      end
    end
  end

  // PC, drain address and hold buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcf        <= RESET_PC;
      r_disc_addr  <= RESET_PC;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      if (BranchTakenE)   r_pcf <= BranchTargetE;
      else if (w_req_ack) r_pcf <= r_pcf + PC_STEP;
      // Frozen while draining so the bus address stays put until the ack.
      if (r_state != ST_DISCARD) r_disc_addr <= r_pcf;
      if (w_req_ack && StallD && !BranchTakenE) begin
        r_hold_instr <= imem_rdata;
        r_hold_pc    <= r_pcf;
      end
    end
  end

  if_id_register #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_flush (FlushD),
    .i_stall (StallD),
    .i_load  (w_load),
    .i_instr (w_load_instr),
    .i_pc    (w_load_pc),
    .o_instr (InstrD),
    .o_pc    (PCD),
    .o_valid (ValidD)
  );

`ifdef FETCH_PERF_EN
  logic        w_fetched, w_drop;
  logic [31:0] r_fetch_cnt, r_stall_cnt;
  logic [15:0] r_disc_cnt;

  assign w_fetched = w_load && !FlushD && !StallD;
  assign w_drop    = imem_ack && ((r_state == ST_DISCARD) ||
                                  ((r_state == ST_REQ) && BranchTakenE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_disc_cnt  <= '0;
    end else begin
      if (w_fetched && (r_fetch_cnt != '1))           r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == ST_HELD) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_drop && (r_disc_cnt != '1))                r_disc_cnt  <= r_disc_cnt + 16'd1;
    end
  end

  assign FetchCount   = r_fetch_cnt;
  assign StallCount   = r_stall_cnt;
  assign DiscardCount = r_disc_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, StallD, FlushD, BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        imem_req, imem_ack, ValidD;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount, StallCount;
  logic [15:0] DiscardCount;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
    , .FetchCount(FetchCount), .StallCount(StallCount), .DiscardCount(DiscardCount)
`endif
  );

  int checks = 0, failures = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: per-request latency, fixed_lat<0 means random 0..3
  int mem_wait = -1, mem_lat = 0, fixed_lat = 0;

  // reference model: what fetch should have done, tracked as plain facts
  bit          m_up, m_doomed, m_held, m_valid;
  logic [31:0] m_pc, m_baddr, m_hi, m_hp, m_instr, m_pcd;
  int unsigned m_fc, m_sc, m_dc;

  function automatic bit exp_req();
    return m_up && !m_held;
  endfunction
  function automatic logic [31:0] exp_addr();
    return m_doomed ? m_baddr : m_pc;
  endfunction

  task automatic model_step(input bit s, f, b, input logic [31:0] t,
                            input bit r, ack, input logic [31:0] rd);
    bit ld, ackq;
    logic [31:0] li, lp;
    if (r) begin
      m_up = 0; m_doomed = 0; m_held = 0; m_valid = 0;
      m_pc = 0; m_baddr = 0; m_instr = 0; m_pcd = 0;
      m_fc = 0; m_sc = 0; m_dc = 0;
      return;
    end
    ld = 0; li = 0; lp = 0;
    ackq = ack && exp_req();
    if (m_up && m_held) m_sc++;
    if (!m_up) begin
      m_up = 1;
      if (b) m_pc = t;
    end else if (m_doomed) begin
      if (ackq) begin m_doomed = 0; m_dc++; end
      if (b) m_pc = t;
    end else if (m_held) begin
      if (b) begin m_held = 0; m_pc = t; end
      else if (!s) begin ld = 1; li = m_hi; lp = m_hp; m_held = 0; end
    end else begin
      if (b) begin
        if (ackq) m_dc++;
        else begin m_doomed = 1; m_baddr = m_pc; end
        m_pc = t;
      end else if (ackq) begin
        if (s) begin m_held = 1; m_hi = rd; m_hp = m_pc; end
        else begin ld = 1; li = rd; lp = m_pc; end
        m_pc = m_pc + 32'd4;
      end
    end
    if (f) begin m_valid = 0; m_instr = 0; end
    else if (s) begin end
    else if (ld) begin m_valid = 1; m_instr = li; m_pcd = lp; m_fc++; end
    else m_valid = 0;
  endtask

  // one clock: drive inputs, answer memory, step model, land on negedge
  task automatic cycle(input bit s, f, b, input logic [31:0] t, input bit r, input bit xack);
    bit req_s, ack;
    logic [31:0] rd;
    StallD = s; FlushD = f; BranchTakenE = b; BranchTargetE = t; rst = r;
    req_s = imem_req;
    ack = 0;
    if (req_s) begin
      if (mem_wait < 0) begin
        mem_wait = 0;
        mem_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      ack = (mem_wait >= mem_lat);
    end
    if (xack) ack = 1;
    rd = ack ? instr_of(imem_addr) : $urandom;
    imem_ack = ack; imem_rdata = rd;
    @(posedge clk);
    model_step(s, f, b, t, r, ack, rd);
    if (r || ack) mem_wait = -1;
    else if (req_s) mem_wait++;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset(input int lat);
    fixed_lat = lat;
    cycle(0, 0, 0, 32'h0, 1, 0);
    cycle(0, 0, 0, 32'h0, 1, 0);
  endtask

  typedef struct {
    bit s, f, b; logic [31:0] t;
    bit er; logic [31:0] ea; bit ev;
    logic [31:0] ep; bit cp;
    logic [31:0] ei; bit ci;
  } vec_t;
  vec_t tbl[15];

  initial begin
    rst = 1; StallD = 0; FlushD = 0; BranchTakenE = 0; BranchTargetE = 0;
    imem_ack = 0; imem_rdata = 0;

    // cycle-by-cycle after reset release, zero-wait memory
    tbl[0]  = '{0,0,0,32'h0,   0,32'h0,  0, 32'h0,  1, 32'h0,           1};
    tbl[1]  = '{0,0,0,32'h0,   1,32'h0,  0, 32'h0,  1, 32'h0,           1};
    tbl[2]  = '{0,0,0,32'h0,   1,32'h4,  1, 32'h0,  1, instr_of(32'h0), 1};
    tbl[3]  = '{1,0,0,32'h0,   1,32'h8,  1, 32'h4,  1, instr_of(32'h4), 1};
    tbl[4]  = '{1,0,0,32'h0,   0,32'hC,  1, 32'h4,  1, instr_of(32'h4), 1};
    tbl[5]  = '{1,0,0,32'h0,   0,32'hC,  1, 32'h4,  1, instr_of(32'h4), 1};
    tbl[6]  = '{1,0,0,32'h0,   0,32'hC,  1, 32'h4,  1, instr_of(32'h4), 1};
    tbl[7]  = '{0,0,0,32'h0,   0,32'hC,  1, 32'h4,  1, instr_of(32'h4), 1};
    tbl[8]  = '{0,0,0,32'h0,   1,32'hC,  1, 32'h8,  1, instr_of(32'h8), 1};
    tbl[9]  = '{1,1,0,32'h0,   1,32'h10, 1, 32'hC,  1, instr_of(32'hC), 1};
    tbl[10] = '{0,0,0,32'h0,   0,32'h14, 0, 32'h0,  0, 32'h0,           1};
    tbl[11] = '{0,0,1,32'h200, 1,32'h14, 1, 32'h10, 1, instr_of(32'h10),1};
    tbl[12] = '{0,0,0,32'h0,   1,32'h200,0, 32'h0,  0, 32'h0,           0};
    tbl[13] = '{0,0,0,32'h0,   1,32'h204,1, 32'h200,1, instr_of(32'h200),1};
    tbl[14] = '{0,0,0,32'h0,   1,32'h208,1, 32'h204,1, instr_of(32'h204),1};

    @(negedge clk);
    do_reset(0);
    chk("reset imem_req", imem_req, 0);
    chk("reset imem_addr", imem_addr, 0);
    chk("reset InstrD", InstrD, 0);
    chk("reset PCD", PCD, 0);
    chk("reset ValidD", ValidD, 0);

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tbl%0d imem_req", i), imem_req, tbl[i].er);
      chk($sformatf("tbl%0d imem_addr", i), imem_addr, tbl[i].ea);
      chk($sformatf("tbl%0d ValidD", i), ValidD, tbl[i].ev);
      if (tbl[i].cp) chk($sformatf("tbl%0d PCD", i), PCD, tbl[i].ep);
      if (tbl[i].ci) chk($sformatf("tbl%0d InstrD", i), InstrD, tbl[i].ei);
      cycle(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].t, 0, 0);
    end

    // 3-cycle response: request to 0x4 stays put until ack
    do_reset(0);
    idle_cycle(); idle_cycle();
    fixed_lat = 2;
    for (int k = 0; k < 3; k++) begin
      chk("lat imem_req", imem_req, 1);
      chk("lat imem_addr", imem_addr, 32'h4);
      idle_cycle();
    end
    chk("lat InstrD", InstrD, instr_of(32'h4));
    chk("lat ValidD", ValidD, 1);
    chk("lat PCD", PCD, 32'h4);
    chk("lat next addr", imem_addr, 32'h8);

    // redirect while fetch of 0x10 outstanding
    do_reset(0);
    for (int k = 0; k < 5; k++) idle_cycle();
    chk("disc pre addr", imem_addr, 32'h10);
    fixed_lat = 2;
    cycle(0, 0, 1, 32'h100, 0, 0);
    chk("disc req held", imem_req, 1);
    chk("disc addr held", imem_addr, 32'h10);
    idle_cycle();
    chk("disc addr held2", imem_addr, 32'h10);
    idle_cycle();
    chk("disc target req", imem_req, 1);
    chk("disc target addr", imem_addr, 32'h100);
    for (int k = 0; k < 3; k++) begin
      chk("disc no 0x10", (ValidD && PCD == 32'h10), 0);
      idle_cycle();
    end
    chk("disc ValidD", ValidD, 1);
    chk("disc PCD", PCD, 32'h100);
    chk("disc InstrD", InstrD, instr_of(32'h100));
`ifdef FETCH_PERF_EN
    chk("disc DiscardCount", DiscardCount, 1);
`endif

    // reset pulsed mid-wait, then a stale ack lands in IDLE
    do_reset(0);
    idle_cycle(); idle_cycle(); idle_cycle();
    fixed_lat = 3;
    idle_cycle();
    chk("rstmid PCD before", PCD, 32'h4);
    cycle(0, 0, 0, 32'h0, 1, 0);
    chk("rstmid imem_req", imem_req, 0);
    chk("rstmid imem_addr", imem_addr, 0);
    chk("rstmid InstrD", InstrD, 0);
    chk("rstmid PCD", PCD, 0);
    chk("rstmid ValidD", ValidD, 0);
    cycle(0, 0, 0, 32'h0, 0, 1);
    chk("stale ValidD", ValidD, 0);
    chk("stale InstrD", InstrD, 0);
    chk("stale PCD", PCD, 0);
    chk("stale imem_req", imem_req, 1);
    chk("stale imem_addr", imem_addr, 0);

    // random traffic against the model
    do_reset(-1);
    for (int n = 0; n < 4000; n++) begin
      bit s, f, b, r;
      logic [31:0] t;
      chk("rnd imem_req", imem_req, exp_req());
      chk("rnd imem_addr", imem_addr, exp_addr());
      chk("rnd ValidD", ValidD, m_valid);
      chk("rnd InstrD", InstrD, m_instr);
      chk("rnd PCD", PCD, m_pcd);
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00})
                                      : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      cycle(s, f, b, t, r, 0);
    end
`ifdef FETCH_PERF_EN
    chk("rnd FetchCount", FetchCount, m_fc);
    chk("rnd StallCount", StallCount, m_sc);
    chk("rnd DiscardCount", {16'h0, DiscardCount}, (m_dc > 65535) ? 32'hFFFF : m_dc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
